ba_serial: RTL and testbench



---
 rtl/ba_pkg.sv | 16 +
 rtl/ba_serial_if.sv | 27 ++
 rtl/ba_digit_add.sv | 24 ++
 rtl/ba_serial.sv | 95 +++++++++
 tb/tb_ba_serial.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ba_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package ba_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ba_state_e;

  // True when the width/digit pair can be built.
  function automatic bit ba_params_ok(int width, int digit);
    if (digit < 1 || width < 2) return 1'b0;
    return (width % digit) == 0;
  endfunction

endpackage

// File: rtl/ba_serial_if.sv
// Operand/result bundle. in_valid/in_ready and out_valid/out_ready are each a
// valid/ready pair: a transfer happens on a rising clk edge where both are 1.
interface ba_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/ba_digit_add.sv
// DIGIT-bit combinational ripple adder built from full-adder cells; also
// reports the carry entering its MSB for overflow detection.
module ba_digit_add #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);
  logic [DIGIT:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[DIGIT];
  assign cmsb_o = c[DIGIT-1];
endmodule

// File: rtl/ba_serial.sv
// Digit-serial adder/subtractor: adds DIGIT bits per cycle, LSB slice first,
// chaining the carry through a register between cycles.
module ba_serial
  import ba_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic      clk,
  input  logic      rst,
  ba_serial_if.slave bus,
  output ba_state_e state_o
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (!ba_params_ok(WIDTH, DIGIT)) begin : g_param_err
    $error("ba_serial: WIDTH must be >= 2, DIGIT >= 1, and DIGIT must divide WIDTH");
  end

  ba_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co;
  logic             slice_cmsb;

  assign slice_a = a_q[int'(cnt_q) * DIGIT +: DIGIT];
  assign slice_b = b_q[int'(cnt_q) * DIGIT +: DIGIT];

  ba_digit_add #(.DIGIT(DIGIT)) u_digit (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_s),
    .cout_o (slice_co),
    .cmsb_o (slice_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is A + ~B + 1; cin is ignored in that mode.
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[int'(cnt_q) * DIGIT +: DIGIT] <= slice_s;
          carry_q <= slice_co;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cout_q  <= slice_co;
            ovf_q   <= slice_cmsb ^ slice_co;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_ba_serial.sv
// Bench for ba_serial: three instances (DIGIT=2, 1, 8) driven with identical
// operands, checked against hand-computed vectors and a reference model.
module tb_ba_serial;
  import ba_pkg::*;

  localparam int W = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid_s = 1'b0;
  logic [W-1:0] a_s = '0;
  logic [W-1:0] b_s = '0;
  logic         cin_s = 1'b0;
  logic         sub_s = 1'b0;
  logic         out_ready_s = 1'b1;

  ba_serial_if #(.WIDTH(W)) if0 ();
  ba_serial_if #(.WIDTH(W)) if1 ();
  ba_serial_if #(.WIDTH(W)) if2 ();

  ba_state_e st[NI];

  ba_serial #(.WIDTH(W), .DIGIT(2)) u_d2 (.clk(clk), .rst(rst), .bus(if0.slave), .state_o(st[0]));
  ba_serial #(.WIDTH(W), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1.slave), .state_o(st[1]));
  ba_serial #(.WIDTH(W), .DIGIT(8)) u_d8 (.clk(clk), .rst(rst), .bus(if2.slave), .state_o(st[2]));

  assign if0.in_valid = in_valid_s; assign if1.in_valid = in_valid_s; assign if2.in_valid = in_valid_s;
  assign if0.a = a_s;               assign if1.a = a_s;               assign if2.a = a_s;
  assign if0.b = b_s;               assign if1.b = b_s;               assign if2.b = b_s;
  assign if0.cin = cin_s;           assign if1.cin = cin_s;           assign if2.cin = cin_s;
  assign if0.sub = sub_s;           assign if1.sub = sub_s;           assign if2.sub = sub_s;
  assign if0.out_ready = out_ready_s; assign if1.out_ready = out_ready_s; assign if2.out_ready = out_ready_s;

  logic         ov[NI];
  logic         ir[NI];
  logic [W-1:0] sm[NI];
  logic         co[NI];
  logic         of[NI];

  assign ov[0] = if0.out_valid; assign ov[1] = if1.out_valid; assign ov[2] = if2.out_valid;
  assign ir[0] = if0.in_ready;  assign ir[1] = if1.in_ready;  assign ir[2] = if2.in_ready;
  assign sm[0] = if0.sum;       assign sm[1] = if1.sum;       assign sm[2] = if2.sum;
  assign co[0] = if0.cout;      assign co[1] = if1.cout;      assign co[2] = if2.cout;
  assign of[0] = if0.ovf;       assign of[1] = if1.ovf;       assign of[2] = if2.ovf;

  int ndig[NI] = '{4, 8, 1};

  int checks = 0;
  int errors = 0;

  // Expected result word: {cout, ovf, sum}
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", name, inst, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bx;
    logic [W:0]   r;
    logic         v;
    bx = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    v  = (a[W-1] == bx[W-1]) && (r[W-1] != a[W-1]);
    return {r[W], v, r[W-1:0]};
  endfunction

  // One operation on all instances with out_ready held high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [W+1:0] exp);
    logic         got[NI];
    int           lat[NI];
    logic [W+1:0] res[NI];
    logic [W+1:0] e;
    exp_q.push_back(exp);
    a_s = a; b_s = b; cin_s = cin; sub_s = sub;
    in_valid_s = 1'b1;
    tick();
    in_valid_s = 1'b0;
    for (int i = 0; i < NI; i++) begin got[i] = 1'b0; lat[i] = 0; res[i] = '0; end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      // cin flips mid-operation; it must not matter once captured
      cin_s = ~cin_s;
      for (int i = 0; i < NI; i++) begin
        if (!got[i] && ov[i]) begin
          got[i] = 1'b1;
          lat[i] = cyc;
          res[i] = {co[i], of[i], sm[i]};
        end
      end
    end
    e = exp_q.pop_front();
    for (int i = 0; i < NI; i++) begin
      chk("got_valid", i, 32'(got[i]), 32'd1);
      chk("latency", i, lat[i], ndig[i]);
      chk("sum", i, 32'(res[i][W-1:0]), 32'(e[W-1:0]));
      chk("cout", i, 32'(res[i][W+1]), 32'(e[W+1]));
      chk("ovf", i, 32'(res[i][W]), 32'(e[W]));
    end
  endtask

  initial begin
    vecs[0] = '{8'h06, 8'h0A, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{8'h3C, 8'h41, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0};

    // Reset with in_valid asserted: it must be ignored.
    rst = 1'b1;
    in_valid_s = 1'b1;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("rst_state", i, 32'(st[i]), 32'(IDLE));
      chk("rst_in_ready", i, 32'(ir[i]), 32'd1);
      chk("rst_out_valid", i, 32'(ov[i]), 32'd0);
      chk("rst_sum", i, 32'(sm[i]), 32'd0);
      chk("rst_cout", i, 32'(co[i]), 32'd0);
      chk("rst_ovf", i, 32'(of[i]), 32'd0);
    end
    in_valid_s = 1'b0;
    rst = 1'b0;
    tick();

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub,
             {vecs[v].e_cout, vecs[v].e_ovf, vecs[v].e_sum});
    end

    for (int r = 0; r < 16; r++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    // Backpressure: result held while out_ready low; in_valid must not be taken.
    begin
      logic all_v;
      out_ready_s = 1'b0;
      a_s = 8'h06; b_s = 8'h0A; cin_s = 1'b0; sub_s = 1'b0;
      in_valid_s = 1'b1;
      tick();
      in_valid_s = 1'b0;
      all_v = 1'b0;
      for (int cyc = 0; cyc < 12 && !all_v; cyc++) begin
        tick();
        all_v = ov[0] && ov[1] && ov[2];
      end
      chk("bp_all_valid", 0, 32'(all_v), 32'd1);
      a_s = 8'h55; b_s = 8'h22;
      in_valid_s = 1'b1;
      for (int h = 0; h < 3; h++) begin
        tick();
        for (int i = 0; i < NI; i++) begin
          chk("bp_out_valid", i, 32'(ov[i]), 32'd1);
          chk("bp_in_ready", i, 32'(ir[i]), 32'd0);
          chk("bp_sum", i, 32'(sm[i]), 32'h10);
          chk("bp_cout", i, 32'(co[i]), 32'd0);
          chk("bp_ovf", i, 32'(of[i]), 32'd0);
        end
      end
      // in_valid stays high across the DONE->IDLE edge: no same-cycle accept.
      out_ready_s = 1'b1;
      tick();
      for (int i = 0; i < NI; i++) begin
        chk("bp_release_out_valid", i, 32'(ov[i]), 32'd0);
        chk("bp_release_in_ready", i, 32'(ir[i]), 32'd1);
        chk("bp_release_state", i, 32'(st[i]), 32'(IDLE));
      end
      in_valid_s = 1'b0;
      tick();
    end

    // Reset during the second RUN cycle aborts with no result.
    begin
      int seen[NI];
      a_s = 8'h01; b_s = 8'h02; cin_s = 1'b0; sub_s = 1'b0;
      in_valid_s = 1'b1;
      tick();
      in_valid_s = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
        chk("abort_state", i, 32'(st[i]), 32'(IDLE));
        chk("abort_in_ready", i, 32'(ir[i]), 32'd1);
        chk("abort_out_valid", i, 32'(ov[i]), 32'd0);
        chk("abort_sum", i, 32'(sm[i]), 32'd0);
        seen[i] = 0;
      end
      for (int cyc = 0; cyc < 12; cyc++) begin
        tick();
        for (int i = 0; i < NI; i++) if (ov[i]) seen[i]++;
      end
      for (int i = 0; i < NI; i++) chk("abort_no_result", i, seen[i], 0);
    end

    // Normal operation resumes after the abort.
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
